// File: rtl/cpu6_pipeline_drain_ctrl_if.sv
// Handshake bundle between the decode/hazard logic and the pipeline drain sequencer.
// The master side raises drain requests and consumes the stall/bubble controls.
interface cpu6_pipeline_drain_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             empty_pipeline_reqD;
   logic             empty_pipeline_reqW;
   logic             flush_in;
   logic             err_clr;
   logic             stallF;
   logic             stallD;
   logic             bubbleE;
   logic             drain_busy;
   logic             drain_done;
   logic             drain_abort;
   logic             drain_timeout;
   logic [CNT_W-1:0] drain_cnt;

   modport master (
      output empty_pipeline_reqD, empty_pipeline_reqW, flush_in, err_clr,
      input  stallF, stallD, bubbleE, drain_busy, drain_done, drain_abort,
             drain_timeout, drain_cnt
   );

   modport slave (
      input  empty_pipeline_reqD, empty_pipeline_reqW, flush_in, err_clr,
      output stallF, stallD, bubbleE, drain_busy, drain_done, drain_abort,
             drain_timeout, drain_cnt
   );
endinterface

// File: rtl/cpu6_pipeline_drain_ctrl.sv
// Pipeline drain sequencer: holds fetch/decode and bubbles E until the drain marker
// retires at W, then waits SETTLE_CYCLES before releasing the front end.
module cpu6_pipeline_drain_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int TIMEOUT       = 64,
   parameter int CNT_W         = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   cpu6_pipeline_drain_ctrl_if.slave        drainIf
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAIN  = 2'd1,
      SETTLE = 2'd2
   } stateT;

   localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT - 1);
   localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

   stateT            stateReg;
   logic [7:0]       waitCntReg;
   logic [3:0]       settleCntReg;
   logic             doneReg;
   logic             abortReg;
   logic             timeoutReg;
   logic [CNT_W-1:0] cntReg;
   logic             busy;
   logic             finishOk;

   assign busy = (stateReg != IDLE);

   // A drain completes normally either straight from DRAIN (no settle) or at the end of SETTLE.
   assign finishOk = !drainIf.flush_in &&
                     (((stateReg == DRAIN) && drainIf.empty_pipeline_reqW && (SETTLE_CYCLES == 0)) ||
                      ((stateReg == SETTLE) && (settleCntReg == SETTLE_LAST)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateReg     <= IDLE;
         waitCntReg   <= '0;
         settleCntReg <= '0;
         doneReg      <= 1'b0;
         abortReg     <= 1'b0;
         timeoutReg   <= 1'b0;
         cntReg       <= '0;
      end else begin
         doneReg  <= 1'b0;
         abortReg <= 1'b0;
         if (drainIf.err_clr) begin
            timeoutReg <= 1'b0;
         end
         if (finishOk && !(&cntReg)) begin
            cntReg <= cntReg + 1'b1;
         end
         case (stateReg)
            IDLE: begin
               if (drainIf.empty_pipeline_reqD && !drainIf.flush_in) begin
                  stateReg   <= DRAIN;
                  waitCntReg <= '0;
               end
            end
            DRAIN: begin
               if (drainIf.flush_in) begin
                  stateReg <= IDLE;
                  abortReg <= 1'b1;
               end else if (drainIf.empty_pipeline_reqW) begin
                  if (SETTLE_CYCLES == 0) begin
                     stateReg <= IDLE;
                     doneReg  <= 1'b1;
                  end else begin
                     stateReg     <= SETTLE;
                     settleCntReg <= '0;
                  end
               end else if (waitCntReg == WAIT_LAST) begin
                  // Timeout set overrides a simultaneous err_clr.
                  stateReg   <= IDLE;
                  abortReg   <= 1'b1;
                  timeoutReg <= 1'b1;
               end else begin
                  waitCntReg <= waitCntReg + 8'd1;
               end
            end
            SETTLE: begin
               if (drainIf.flush_in) begin
                  stateReg <= IDLE;
                  abortReg <= 1'b1;
               end else if (settleCntReg == SETTLE_LAST) begin
                  stateReg <= IDLE;
                  doneReg  <= 1'b1;
               end else begin
                  settleCntReg <= settleCntReg + 4'd1;
               end
            end
            default: stateReg <= IDLE;
         endcase
      end
   end

   assign drainIf.stallF        = busy;
   assign drainIf.stallD        = busy;
   assign drainIf.bubbleE       = busy;
   assign drainIf.drain_busy    = busy;
   assign drainIf.drain_done    = doneReg;
   assign drainIf.drain_abort   = abortReg;
   assign drainIf.drain_timeout = timeoutReg;
   assign drainIf.drain_cnt     = cntReg;
endmodule

// File: tb/tb_cpu6_pipeline_drain_ctrl.sv
// Directed bench for the drain sequencer: two instances cover SETTLE_CYCLES=2 and 0.
module tb_cpu6_pipeline_drain_ctrl;
   logic clk;
   logic reset;
   int   passCnt;
   int   checkCnt;

   cpu6_pipeline_drain_ctrl_if #(.CNT_W(2))  ifA ();
   cpu6_pipeline_drain_ctrl_if #(.CNT_W(16)) ifB ();

   cpu6_pipeline_drain_ctrl #(.SETTLE_CYCLES(2), .TIMEOUT(8), .CNT_W(2)) uA (
      .clk     (clk),
      .reset   (reset),
      .drainIf (ifA)
   );

   cpu6_pipeline_drain_ctrl #(.SETTLE_CYCLES(0), .TIMEOUT(64), .CNT_W(16)) uB (
      .clk     (clk),
      .reset   (reset),
      .drainIf (ifB)
   );

   // {stallF, stallD, bubbleE, busy, done, abort, timeout}
   logic [6:0] outsA;
   logic [6:0] outsB;
   assign outsA = {ifA.stallF, ifA.stallD, ifA.bubbleE, ifA.drain_busy,
                   ifA.drain_done, ifA.drain_abort, ifA.drain_timeout};
   assign outsB = {ifB.stallF, ifB.stallD, ifB.bubbleE, ifB.drain_busy,
                   ifB.drain_done, ifB.drain_abort, ifB.drain_timeout};

   localparam logic [6:0] O_IDLE  = 7'b0000000;
   localparam logic [6:0] O_BUSY  = 7'b1111000;
   localparam logic [6:0] O_DONE  = 7'b0000100;
   localparam logic [6:0] O_ABORT = 7'b0000010;
   localparam logic [6:0] O_TOUT  = 7'b0000001;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ifA.empty_pipeline_reqD = 0; ifA.empty_pipeline_reqW = 0; ifA.flush_in = 0; ifA.err_clr = 0;
      ifB.empty_pipeline_reqD = 0; ifB.empty_pipeline_reqW = 0; ifB.flush_in = 0; ifB.err_clr = 0;
      #2 reset = 1'b0;
      nextCycle();
      nextCycle();
      checkCnt++;
      if (outsA !== O_IDLE || ifA.drain_cnt !== 2'd0) $display("FAIL reset_A outs=%b cnt=%0d required outs=%b cnt=0", outsA, ifA.drain_cnt, O_IDLE);
      else passCnt++;
      checkCnt++;
      if (outsB !== O_IDLE || ifB.drain_cnt !== 16'd0) $display("FAIL reset_B outs=%b cnt=%0d required outs=%b cnt=0", outsB, ifB.drain_cnt, O_IDLE);
      else passCnt++;
      reset = 1'b1;
      nextCycle();
      $display("test_reset done");
   endtask

   task automatic test_basic();
      logic [6:0] exp;
      for (int k = 0; k <= 8; k++) begin
         exp = (k >= 1 && k <= 6) ? O_BUSY : (k == 7) ? O_DONE : O_IDLE;
         checkCnt++;
         if (outsA !== exp) $display("FAIL basic c%0d outs=%b required %b", k, outsA, exp);
         else passCnt++;
         ifA.empty_pipeline_reqD = (k == 0);
         ifA.empty_pipeline_reqW = (k == 4);
         nextCycle();
      end
      checkCnt++;
      if (ifA.drain_cnt !== 2'd1) $display("FAIL basic_cnt cnt=%0d required 1", ifA.drain_cnt);
      else passCnt++;
      $display("test_basic done cnt=%0d", ifA.drain_cnt);
   endtask

   task automatic test_zero_settle();
      logic [6:0] exp;
      for (int k = 0; k <= 5; k++) begin
         exp = (k >= 1 && k <= 3) ? O_BUSY : (k == 4) ? O_DONE : O_IDLE;
         checkCnt++;
         if (outsB !== exp) $display("FAIL zero_settle c%0d outs=%b required %b", k, outsB, exp);
         else passCnt++;
         ifB.empty_pipeline_reqD = (k == 0);
         ifB.empty_pipeline_reqW = (k == 3);
         nextCycle();
      end
      checkCnt++;
      if (ifB.drain_cnt !== 16'd1) $display("FAIL zero_settle_cnt cnt=%0d required 1", ifB.drain_cnt);
      else passCnt++;
      $display("test_zero_settle done cnt=%0d", ifB.drain_cnt);
   endtask

   task automatic test_flush_abort();
      logic [6:0] exp;
      for (int k = 0; k <= 6; k++) begin
         exp = (k == 1 || k == 2) ? O_BUSY : (k == 3) ? O_ABORT : O_IDLE;
         checkCnt++;
         if (outsA !== exp) $display("FAIL flush_abort c%0d outs=%b required %b", k, outsA, exp);
         else passCnt++;
         ifA.empty_pipeline_reqD = (k == 0);
         ifA.flush_in            = (k == 2);
         ifA.empty_pipeline_reqW = (k == 4);
         nextCycle();
      end
      checkCnt++;
      if (ifA.drain_cnt !== 2'd1) $display("FAIL flush_abort_cnt cnt=%0d required 1", ifA.drain_cnt);
      else passCnt++;
      $display("test_flush_abort done");
   endtask

   task automatic test_timeout();
      logic [6:0] exp;
      for (int k = 0; k <= 13; k++) begin
         exp = (k >= 1 && k <= 8) ? O_BUSY : (k == 9) ? (O_ABORT | O_TOUT) :
               (k >= 10 && k <= 12) ? O_TOUT : O_IDLE;
         checkCnt++;
         if (outsA !== exp) $display("FAIL timeout c%0d outs=%b required %b", k, outsA, exp);
         else passCnt++;
         ifA.empty_pipeline_reqD = (k == 0);
         ifA.err_clr             = (k == 12);
         nextCycle();
      end
      // err_clr coincident with the timeout edge: the set must win.
      for (int k = 0; k <= 11; k++) begin
         exp = (k >= 1 && k <= 8) ? O_BUSY : (k == 9) ? (O_ABORT | O_TOUT) :
               (k == 10) ? O_TOUT : O_IDLE;
         checkCnt++;
         if (outsA !== exp) $display("FAIL timeout_setwins c%0d outs=%b required %b", k, outsA, exp);
         else passCnt++;
         ifA.empty_pipeline_reqD = (k == 0);
         ifA.err_clr             = (k == 8 || k == 10);
         nextCycle();
      end
      $display("test_timeout done");
   endtask

   task automatic test_back_to_back();
      logic [6:0] exp;
      logic       busyK;
      for (int k = 0; k <= 16; k++) begin
         busyK = (k >= 1 && k <= 4) || (k >= 6 && k <= 9) || (k >= 11 && k <= 14);
         exp   = busyK ? O_BUSY : (k == 5 || k == 10 || k == 15) ? O_DONE : O_IDLE;
         checkCnt++;
         if (outsA !== exp) $display("FAIL back_to_back c%0d outs=%b required %b", k, outsA, exp);
         else passCnt++;
         if (k == 5 || k == 10 || k == 16) begin
            checkCnt++;
            if (ifA.drain_cnt !== ((k == 5) ? 2'd2 : 2'd3))
               $display("FAIL back_to_back_cnt c%0d cnt=%0d required %0d", k, ifA.drain_cnt, (k == 5) ? 2 : 3);
            else passCnt++;
         end
         ifA.empty_pipeline_reqD = (k <= 10);
         ifA.empty_pipeline_reqW = (k == 2 || k == 7 || k == 12);
         nextCycle();
      end
      $display("test_back_to_back done cnt=%0d", ifA.drain_cnt);
   endtask

   task automatic test_async_reset();
      for (int k = 0; k <= 3; k++) begin
         ifA.empty_pipeline_reqD = (k == 0);
         ifA.empty_pipeline_reqW = (k == 2);
         if (k < 3) nextCycle();
      end
      checkCnt++;
      if (outsA !== O_BUSY) $display("FAIL async_pre c3 outs=%b required %b", outsA, O_BUSY);
      else passCnt++;
      ifA.empty_pipeline_reqW = 0;
      #2 reset = 1'b0;
      #1;
      checkCnt++;
      if (outsA !== O_IDLE || ifA.drain_cnt !== 2'd0) $display("FAIL async_now outs=%b cnt=%0d required outs=%b cnt=0", outsA, ifA.drain_cnt, O_IDLE);
      else passCnt++;
      checkCnt++;
      if (ifB.drain_cnt !== 16'd0) $display("FAIL async_B_cnt cnt=%0d required 0", ifB.drain_cnt);
      else passCnt++;
      nextCycle();
      #3 reset = 1'b1;
      nextCycle();
      checkCnt++;
      if (outsA !== O_IDLE || ifA.drain_cnt !== 2'd0) $display("FAIL async_after outs=%b cnt=%0d required outs=%b cnt=0", outsA, ifA.drain_cnt, O_IDLE);
      else passCnt++;
      ifA.empty_pipeline_reqD = 1'b1;
      nextCycle();
      ifA.empty_pipeline_reqD = 1'b0;
      checkCnt++;
      if (outsA !== O_BUSY) $display("FAIL async_reaccept outs=%b required %b", outsA, O_BUSY);
      else passCnt++;
      $display("test_async_reset done");
   endtask

   initial begin
      passCnt  = 0;
      checkCnt = 0;
      test_reset();
      test_basic();
      test_zero_settle();
      test_flush_abort();
      test_timeout();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end
endmodule
